// File: rtl/timer_pkg.sv
// Shared types and constants for the keypad timer entry block.
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [15:0] QUICK_START_DEF = 16'h0030;
  localparam logic [15:0] MAX_TIME = 16'h9959;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    NORM,
    LOAD
  } state_t;

endpackage

// File: rtl/bcd_time_normalize.sv
// Folds seconds of 60..99 into the minutes field of a BCD mm:ss value,
// saturating at 99:59 when the minute carry would overflow.
module bcd_time_normalize
  import timer_pkg::*;
(
  input  logic [15:0] raw_i,
  output logic [15:0] norm_o
);

  logic [DIGIT_W-1:0] min_tens, min_ones, sec_tens, sec_ones;

  assign {min_tens, min_ones, sec_tens, sec_ones} = raw_i;

  // Digits are never above 9, so S >= 60 exactly when sec_tens >= 6, and
  // subtracting 60 only touches the tens digit.
  always_comb begin
    norm_o = raw_i;
    if (sec_tens >= 4'd6) begin
      if (min_ones == 4'd9) begin
        if (min_tens == 4'd9) begin
          norm_o = MAX_TIME;
        end else begin
          norm_o = {min_tens + 4'd1, 4'd0, sec_tens - 4'd6, sec_ones};
        end
      end else begin
        norm_o = {min_tens, min_ones + 4'd1, sec_tens - 4'd6, sec_ones};
      end
    end
  end

endmodule

// File: rtl/timer_entry.sv
// Keypad-side writer for the down-counting timer digits: collects BCD keys,
// normalises mm:ss and issues a one-cycle active-low load to the counters.
module timer_entry
  import timer_pkg::*;
#(
  parameter logic [15:0] QUICK_START = QUICK_START_DEF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start_req,
  input  logic        cancel,
  input  logic        timer_running,
  output logic [15:0] entry,
  output logic [2:0]  entry_count,
  output logic [15:0] data,
  output logic        loadn,
  output logic        load_done
);

  state_t      state_q;
  logic [15:0] entry_q;
  logic [2:0]  count_q;
  logic [15:0] data_q;
  logic        loadn_q;
  logic        load_done_q;
  logic [15:0] norm_d;
  logic        key_ok;
  logic        accepting;

  bcd_time_normalize u_norm (
    .raw_i  (entry_q),
    .norm_o (norm_d)
  );

  assign accepting = (state_q == IDLE) || (state_q == ENTRY);
  assign key_ok    = key_valid && (key_digit <= 4'd9) && !timer_running
                     && (count_q < 3'd4) && accepting;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      count_q     <= '0;
      data_q      <= '0;
      loadn_q     <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      loadn_q     <= 1'b1;
      load_done_q <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (cancel) begin
            entry_q <= '0;
            count_q <= '0;
            state_q <= IDLE;
          end else if (start_req && !timer_running) begin
            // An empty entry commits the quick-start time instead.
            if (state_q == IDLE) begin
              entry_q <= QUICK_START;
            end
            state_q <= NORM;
          end else if (key_ok) begin
            entry_q <= {entry_q[11:0], key_digit};
            count_q <= count_q + 3'd1;
            state_q <= ENTRY;
          end
        end
        NORM: begin
          data_q  <= norm_d;
          state_q <= LOAD;
        end
        LOAD: begin
          loadn_q     <= 1'b0;
          load_done_q <= 1'b1;
          entry_q     <= '0;
          count_q     <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign entry       = entry_q;
  assign entry_count = count_q;
  assign data        = data_q;
  assign loadn       = loadn_q;
  assign load_done   = load_done_q;

endmodule

// File: doc/timer_entry.md
Name: timer_entry

Overview:
- Keypad-side writer for the cascaded down-counting timer digits (min_tens, min_ones, sec_tens, sec_ones).
- Collects BCD key presses microwave-style and normalises seconds above 59 (e.g. 0:90 becomes 1:30) so sec_tens never exceeds 5.
- Drives the counters' shared data bus and active-low synchronous load strobe.
- Sits between the keypad decoder and the timer counter chain.

Parameters:
- QUICK_START, 16'h0030, BCD value {min_tens,min_ones,sec_tens,sec_ones} loaded when start is pressed with an empty entry.

Ports:
- clock  in  1  system clock, all logic on posedge
- clear  in  1  synchronous reset, active high
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  BCD key value; values above 9 are ignored
- start_req  in  1  one-cycle strobe, commit entry to counters
- cancel  in  1  one-cycle strobe, discard entry
- timer_running  in  1  high while counters are enabled
- entry  out  16  current entered BCD digits, for the display
- entry_count  out  3  number of digits accepted, 0..4
- data  out  16  BCD load value to counters {min_tens,min_ones,sec_tens,sec_ones}
- loadn  out  1  active-low load strobe to counters
- load_done  out  1  one-cycle pulse, coincident with loadn low

Behaviour:
- Reset: one clock, synchronous, active-high. While clear is sampled high at a posedge: state becomes IDLE, entry=0, entry_count=0, data=0, loadn=1, load_done=0. Reset overrides every other input in any state, including mid-NORM or mid-LOAD; an aborted load never asserts loadn.
- States:
  - IDLE: entry_count=0.
  - ENTRY: 1..4 digits held.
  - NORM: normalise for one cycle.
  - LOAD: strobe for one cycle.
- Input priority, per cycle: clear > cancel > start_req > key_valid.
- Accepted key (key_valid=1, key_digit<=9, timer_running=0, state IDLE or ENTRY, entry_count<4):
  - entry <= {entry[11:0], key_digit}.
  - entry_count increments.
  - IDLE moves to ENTRY.
  - A key_digit of 0 counts as a digit.
- Ignored keys (no change to any output): the 5th and later keys (entry_count saturates at 4), digits 10..15, keys while timer_running=1, keys in NORM or LOAD.
- cancel in IDLE or ENTRY: entry=0, entry_count=0, go to IDLE. Allowed while timer_running=1. Ignored in NORM or LOAD.
- start_req with timer_running=0:
  - From ENTRY: go to NORM.
  - From IDLE: entry <= QUICK_START, then go to NORM.
  - A key_valid in the same cycle is dropped.
  - start_req while timer_running=1 is ignored.
- NORM, exactly one cycle:
  - S = 10*sec_tens + sec_ones.
  - If S >= 60: S -= 60 and minutes += 1 (BCD carry from min_ones into min_tens).
  - If minutes would exceed 99, saturate the result to 99:59.
  - Result is registered into data.
  - Entries with S < 60 pass unchanged.
- LOAD, exactly one cycle:
  - loadn=0, load_done=1, data stable.
  - Next state IDLE with entry=0 and entry_count=0.
- Latency: start_req sampled at edge N gives data valid after edge N+1. loadn is low from edge N+2 to N+3, so the counters capture at edge N+3.
- Outside LOAD, loadn=1 and load_done=0 always. data holds its last loaded value.
- Outputs are registered; no combinational path from inputs to loadn or data.

Decomposition:
- Shared package timer_pkg:
  - state enumeration (IDLE, ENTRY, NORM, LOAD);
  - BCD digit width constant (4);
  - QUICK_START default;
  - max-time constant 16'h9959.
- One natural sub-module: bcd_time_normalize, purely combinational. Maps a 16-bit BCD mm:ss to the normalised mm:ss with the saturation rule. It is instantiated once, and its result is registered in NORM.

Test Plan:
- Keys 1,3,0, then start -> entry shows 0x0130 before start; loadn low for exactly 1 cycle at N+2; data=0x0130; entry_count returns to 0.
- Keys 9,0, then start -> data=0x0130 (0:90 normalised to 1:30); load_done coincides with loadn low.
- Keys 9,9,9,9, then start -> data=0x9959 (saturated); a 5th key sent before start does not change entry.
- Start with no keys, timer_running=0 -> data=0x0030 loaded. Same stimulus with timer_running=1 -> loadn stays 1.
- Keys 4,5, then cancel; later start_req and key_valid in the same cycle as each other -> cancel clears entry to 0; start wins and the simultaneous key is dropped; key digit 0xC is ignored.
- Assert clear during NORM -> loadn never goes low; all outputs are 0 (loadn=1) at the next edge; state is IDLE.
